// File: rtl/snitch_cluster_perf_cnt.sv
// ---------------------------------------------------------------------------
// snitch_cluster_perf_cnt
//
// Cluster performance counter block. NumCounters independent counters, each
// of CounterWidth bits, add a software-selected per-cycle event increment.
// Every counter has a threshold interrupt and a sticky overflow flag. An
// optional snapshot bank copies all counters atomically.
//
// Configuration macro:
//   SNITCH_PERF_CNT_SNAPSHOT_EN - when defined, builds the SNAP registers and
//                                 the GLOBAL snapshot trigger. When undefined,
//                                 SNAP_LO/SNAP_HI read the live value and
//                                 GLOBAL bit1 is ignored.
//
// Ports:
//   clk_i     - clock, all state on the rising edge
//   rst_ni    - asynchronous active-low reset
//   events_i  - NumEvents unsigned increments of EventWidth bits each
//   wr_en_i   - register write strobe
//   addr_i    - word address shared by reads and writes
//   wdata_i   - write data
//   rdata_o   - combinational read data for addr_i
//   irq_o     - registered threshold interrupt, one bit per counter
//
// Register map (word addresses):
//   0x000 GLOBAL  bit0 freeze, bit1 snapshot trigger (reads 0)
//   0x001 OVF     sticky overflow per counter, write-1-to-clear
//   0x010+8*i     +0 CTRL (bit0 en, bit1 irq_en, bits15:8 sel)
//                 +1 VAL_LO, +2 VAL_HI, +3 THR_LO, +4 THR_HI,
//                 +5 SNAP_LO, +6 SNAP_HI
// ---------------------------------------------------------------------------
module snitch_cluster_perf_cnt #(
    parameter int NumCounters  = 4,
    parameter int CounterWidth = 48,
    parameter int NumEvents    = 32,
    parameter int EventWidth   = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumEvents-1:0][EventWidth-1:0] events_i,
    input  logic                                 wr_en_i,
    input  logic [9:0]                           addr_i,
    input  logic [31:0]                          wdata_i,
    output logic [31:0]                          rdata_o,
    output logic [NumCounters-1:0]               irq_o
);

    localparam int HiWidth  = CounterWidth - 32;
    localparam int SumWidth = CounterWidth + 1;

    logic [NumEvents-1:0][EventWidth-1:0] events_q;
    logic                                 freeze_q;
    logic [NumCounters-1:0]               ovf_q;
    logic [NumCounters-1:0]               en_q;
    logic [NumCounters-1:0]               irq_en_q;
    logic [NumCounters-1:0]               irq_q;
    logic [7:0]                           sel_q [NumCounters];
    logic [CounterWidth-1:0]              cnt_q [NumCounters];
    logic [CounterWidth-1:0]              thr_q [NumCounters];

    logic                                 global_wr;
    logic                                 ovf_wr;
    logic                                 freeze_next;
    logic [NumCounters-1:0]               blk_hit;
    logic [NumCounters-1:0]               ctrl_wr;
    logic [NumCounters-1:0]               val_lo_wr;
    logic [NumCounters-1:0]               val_hi_wr;
    logic [NumCounters-1:0]               thr_lo_wr;
    logic [NumCounters-1:0]               thr_hi_wr;

    logic [EventWidth-1:0]                ev_val [NumCounters];
    logic [NumCounters-1:0]               ev_ok;
    logic [SumWidth-1:0]                  sum    [NumCounters];
    logic [NumCounters-1:0]               inc;
    logic [NumCounters-1:0]               wrap;

`ifdef SNITCH_PERF_CNT_SNAPSHOT_EN
    logic                                 snap_trig;
    logic [CounterWidth-1:0]              snap_q [NumCounters];
`endif

    // Address decode. Each counter owns an 8-word block starting at 0x010,
    // so addr_i[9:3] picks the block (offset by 2) and addr_i[2:0] the
    // register inside it. The effective freeze for this edge follows a
    // same-cycle GLOBAL write so a freeze stops counting on the edge that
    // writes it.
    always_comb begin
        global_wr   = wr_en_i && (addr_i == 10'h000);
        ovf_wr      = wr_en_i && (addr_i == 10'h001);
        freeze_next = global_wr ? wdata_i[0] : freeze_q;
        for (int i = 0; i < NumCounters; i++) begin
            blk_hit[i]   = (addr_i[9:3] == 7'(i + 2));
            ctrl_wr[i]   = wr_en_i && blk_hit[i] && (addr_i[2:0] == 3'd0);
            val_lo_wr[i] = wr_en_i && blk_hit[i] && (addr_i[2:0] == 3'd1);
            val_hi_wr[i] = wr_en_i && blk_hit[i] && (addr_i[2:0] == 3'd2);
            thr_lo_wr[i] = wr_en_i && blk_hit[i] && (addr_i[2:0] == 3'd3);
            thr_hi_wr[i] = wr_en_i && blk_hit[i] && (addr_i[2:0] == 3'd4);
        end
    end

`ifdef SNITCH_PERF_CNT_SNAPSHOT_EN
    assign snap_trig = global_wr && wdata_i[1];
`endif

    // Increment datapath. The event mux scans all legal event indices so an
    // out-of-range sel simply never matches and the counter never moves.
    // The extra sum bit is the carry-out; it only raises an overflow when
    // the increment is actually committed, i.e. not displaced by a write.
    always_comb begin
        for (int i = 0; i < NumCounters; i++) begin
            ev_val[i] = '0;
            ev_ok[i]  = 1'b0;
            for (int e = 0; e < NumEvents; e++) begin
                if (sel_q[i] == 8'(e)) begin
                    ev_val[i] = events_q[e];
                    ev_ok[i]  = 1'b1;
                end
            end
            sum[i]  = {1'b0, cnt_q[i]} + SumWidth'(ev_val[i]);
            inc[i]  = en_q[i] && !freeze_next && ev_ok[i];
            wrap[i] = inc[i] && sum[i][CounterWidth]
                      && !(val_lo_wr[i] || val_hi_wr[i]);
        end
    end

    // Main state. Software writes to VAL win over a same-cycle increment.
    // OVF clears first and then ORs in new wraps, so a wrap coinciding with
    // a W1C leaves the bit set. The interrupt level compares the current
    // registered value and therefore trails the value by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            events_q <= '0;
            freeze_q <= 1'b0;
            ovf_q    <= '0;
            en_q     <= '0;
            irq_en_q <= '0;
            irq_q    <= '0;
            for (int i = 0; i < NumCounters; i++) begin
                sel_q[i] <= '0;
                cnt_q[i] <= '0;
                thr_q[i] <= '0;
            end
        end else begin
            events_q <= events_i;
            freeze_q <= freeze_next;
            ovf_q    <= (ovf_q & ~(ovf_wr ? wdata_i[NumCounters-1:0]
                                          : {NumCounters{1'b0}})) | wrap;
            for (int i = 0; i < NumCounters; i++) begin
                irq_q[i] <= irq_en_q[i] && (cnt_q[i] >= thr_q[i]);
                if (ctrl_wr[i]) begin
                    en_q[i]     <= wdata_i[0];
                    irq_en_q[i] <= wdata_i[1];
                    sel_q[i]    <= wdata_i[15:8];
                end
                if (val_lo_wr[i]) begin
                    cnt_q[i][31:0] <= wdata_i;
                end else if (val_hi_wr[i]) begin
                    cnt_q[i][CounterWidth-1:32] <= wdata_i[HiWidth-1:0];
                end else if (inc[i]) begin
                    cnt_q[i] <= sum[i][CounterWidth-1:0];
                end
                if (thr_lo_wr[i]) begin
                    thr_q[i][31:0] <= wdata_i;
                end else if (thr_hi_wr[i]) begin
                    thr_q[i][CounterWidth-1:32] <= wdata_i[HiWidth-1:0];
                end
            end
        end
    end

`ifdef SNITCH_PERF_CNT_SNAPSHOT_EN
    // Snapshot bank. It copies cnt_q as it stands before the edge, which is
    // the pre-increment value, and shares the edge with any same-write
    // freeze.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumCounters; i++) begin
                snap_q[i] <= '0;
            end
        end else if (snap_trig) begin
            for (int i = 0; i < NumCounters; i++) begin
                snap_q[i] <= cnt_q[i];
            end
        end
    end
`endif

    assign irq_o = irq_q;

    // Read mux. Unmapped words, including offset 7 of each block and blocks
    // beyond NumCounters, fall through to zero.
    always_comb begin
        rdata_o = '0;
        if (addr_i == 10'h000) begin
            rdata_o = {31'b0, freeze_q};
        end else if (addr_i == 10'h001) begin
            rdata_o = 32'(ovf_q);
        end else begin
            for (int i = 0; i < NumCounters; i++) begin
                if (blk_hit[i]) begin
                    case (addr_i[2:0])
                        3'd0:    rdata_o = {16'b0, sel_q[i], 6'b0, irq_en_q[i], en_q[i]};
                        3'd1:    rdata_o = cnt_q[i][31:0];
                        3'd2:    rdata_o = 32'(cnt_q[i][CounterWidth-1:32]);
                        3'd3:    rdata_o = thr_q[i][31:0];
                        3'd4:    rdata_o = 32'(thr_q[i][CounterWidth-1:32]);
`ifdef SNITCH_PERF_CNT_SNAPSHOT_EN
                        3'd5:    rdata_o = snap_q[i][31:0];
                        3'd6:    rdata_o = 32'(snap_q[i][CounterWidth-1:32]);
`else
                        3'd5:    rdata_o = cnt_q[i][31:0];
                        3'd6:    rdata_o = 32'(cnt_q[i][CounterWidth-1:32]);
`endif
                        default: rdata_o = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_snitch_cluster_perf_cnt.sv
// ---------------------------------------------------------------------------
// tb_snitch_cluster_perf_cnt
//
// Self-checking bench for snitch_cluster_perf_cnt at default parameters
// (4 counters, 48-bit, 32 events of 8 bits). Directed scenarios cover basic
// counting, overflow, write priority, threshold interrupt, snapshot/freeze
// and asynchronous reset; a randomized phase then exercises the register
// map against a behavioural model of the counter block.
// ---------------------------------------------------------------------------
module tb_snitch_cluster_perf_cnt;

    localparam logic [63:0] Mask48 = 64'h0000_FFFF_FFFF_FFFF;

    logic              clk;
    logic              rst_n;
    logic [31:0][7:0]  events;
    logic              wr_en;
    logic [9:0]        addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [3:0]        irq;

    int checks;
    int failures;

    // Behavioural model state
    logic [63:0] mVal  [4];
    logic [63:0] mThr  [4];
    logic [63:0] mSnap [4];
    bit          mEn   [4];
    bit          mIrqEn[4];
    int          mSel  [4];
    bit          mIrq  [4];
    bit          mFreeze;
    logic [3:0]  mOvf;
    int          mEvReg[32];
    int          evNow [32];

    snitch_cluster_perf_cnt dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .events_i (events),
        .wr_en_i  (wr_en),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .irq_o    (irq)
    );

    // Slow clock leaves room for several combinational reads per half cycle
    initial clk = 1'b0;
    always #100 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int adr(input int i, input int off);
        return 16 + 8 * i + off;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mVal[i] = '0; mThr[i] = '0; mSnap[i] = '0;
            mEn[i] = 0; mIrqEn[i] = 0; mSel[i] = 0; mIrq[i] = 0;
        end
        mFreeze = 0;
        mOvf    = '0;
        for (int e = 0; e < 32; e++) mEvReg[e] = 0;
    endtask

    // One rising edge of the reference model, given this cycle's write
    task automatic modelEdge(input bit wr, input int a, input logic [31:0] d);
        bit         freezeN;
        logic [3:0] newOvf;
        logic [63:0] s;
        int         base;
        freezeN = (wr && a == 0) ? d[0] : mFreeze;
        newOvf  = '0;
        for (int i = 0; i < 4; i++) mIrq[i] = mIrqEn[i] && (mVal[i] >= mThr[i]);
`ifdef SNITCH_PERF_CNT_SNAPSHOT_EN
        if (wr && a == 0 && d[1]) for (int i = 0; i < 4; i++) mSnap[i] = mVal[i];
`endif
        for (int i = 0; i < 4; i++) begin
            base = adr(i, 0);
            if (wr && a == base + 1) begin
                mVal[i] = {mVal[i][63:32], d};
            end else if (wr && a == base + 2) begin
                mVal[i] = {16'b0, d[15:0], mVal[i][31:0]};
            end else if (mEn[i] && !freezeN && mSel[i] < 32) begin
                s = mVal[i] + 64'(mEvReg[mSel[i]]);
                if (s > Mask48) begin
                    newOvf[i] = 1'b1;
                    s = s & Mask48;
                end
                mVal[i] = s;
            end
            if (wr && a == base) begin
                mEn[i] = d[0]; mIrqEn[i] = d[1]; mSel[i] = int'(d[15:8]);
            end
            if (wr && a == base + 3) mThr[i] = {mThr[i][63:32], d};
            if (wr && a == base + 4) mThr[i] = {16'b0, d[15:0], mThr[i][31:0]};
        end
        if (wr && a == 1) mOvf = mOvf & ~d[3:0];
        mOvf    = mOvf | newOvf;
        mFreeze = freezeN;
        for (int e = 0; e < 32; e++) mEvReg[e] = evNow[e];
    endtask

    function automatic logic [31:0] modelRead(input int a);
        int i, off;
        if (a == 0) return {31'b0, mFreeze};
        if (a == 1) return {28'b0, mOvf};
        if (a < 16 || a >= 48) return 32'h0;
        i   = (a - 16) / 8;
        off = (a - 16) % 8;
        case (off)
            0: return {16'b0, 8'(mSel[i]), 6'b0, mIrqEn[i], mEn[i]};
            1: return mVal[i][31:0];
            2: return mVal[i][63:32];
            3: return mThr[i][31:0];
            4: return mThr[i][63:32];
`ifdef SNITCH_PERF_CNT_SNAPSHOT_EN
            5: return mSnap[i][31:0];
            6: return mSnap[i][63:32];
`else
            5: return mVal[i][31:0];
            6: return mVal[i][63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Drive one cycle (inputs set at the falling edge, committed at the
    // next rising edge) and advance the model by the same edge
    task automatic applyStimulus(input bit wr, input int a, input logic [31:0] d);
        wr_en = wr;
        addr  = 10'(a);
        wdata = d;
        for (int e = 0; e < 32; e++) events[e] = 8'(evNow[e]);
        modelEdge(wr, a, d);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int a, input logic [31:0] exp);
        addr = 10'(a);
        #1;
        checks++;
        assert (rdata === exp) else begin
            failures++;
            $error("[TB] FAIL %s addr=%0h observed=%h expected=%h", tag, a, rdata, exp);
        end
    endtask

    task automatic checkIrq(input string tag, input logic [3:0] exp);
        #1;
        checks++;
        assert (irq === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, irq, exp);
        end
    endtask

    function automatic logic [3:0] modelIrq();
        return {mIrq[3], mIrq[2], mIrq[1], mIrq[0]};
    endfunction

    initial begin
        int  r, a, ra;
        logic [31:0] d;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        addr     = '0;
        wdata    = '0;
        events   = '0;
        for (int e = 0; e < 32; e++) evNow[e] = 0;
        modelReset();

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 56; k++) checkOutput("reset_reg", k, 32'h0);
        checkIrq("reset_irq", 4'b0000);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);

        // Basic count: 10 cycles of 5 on event 3
        applyStimulus(1, adr(0, 0), 32'h0000_0301);
        evNow[3] = 5;
        repeat (10) applyStimulus(0, 0, 0);
        evNow[3] = 0;
        repeat (2) applyStimulus(0, 0, 0);
        checkOutput("basic_lo", adr(0, 1), 32'd50);
        checkOutput("basic_hi", adr(0, 2), 32'd0);

        // Overflow wrap, then a W1C coinciding with a second wrap
        applyStimulus(1, adr(0, 2), 32'h0000_FFFF);
        applyStimulus(1, adr(0, 1), 32'hFFFF_FFFE);
        checkOutput("ovf_nowrite", 1, 32'h0);
        evNow[3] = 3;
        applyStimulus(0, 0, 0);
        evNow[3] = 0;
        applyStimulus(0, 0, 0);
        checkOutput("wrap_lo", adr(0, 1), 32'd1);
        checkOutput("wrap_hi", adr(0, 2), 32'd0);
        checkOutput("wrap_ovf", 1, 32'h1);
        applyStimulus(1, adr(0, 2), 32'h0000_FFFF);
        applyStimulus(1, adr(0, 1), 32'hFFFF_FFFE);
        evNow[3] = 3;
        applyStimulus(0, 0, 0);
        evNow[3] = 0;
        applyStimulus(1, 1, 32'h1);
        checkOutput("ovf_sticky", 1, 32'h1);
        applyStimulus(1, 1, 32'h1);
        checkOutput("ovf_clear", 1, 32'h0);

        // Write priority over a same-cycle increment of 7
        evNow[3] = 7;
        applyStimulus(0, 0, 0);
        evNow[3] = 0;
        applyStimulus(1, adr(0, 1), 32'd100);
        checkOutput("wr_prio_lo", adr(0, 1), 32'd100);
        checkOutput("wr_prio_ovf", 1, 32'h0);

        // Threshold interrupt with 4 per cycle against threshold 20
        applyStimulus(1, adr(0, 1), 32'd0);
        applyStimulus(1, adr(0, 3), 32'd20);
        applyStimulus(1, adr(0, 0), 32'h0000_0303);
        evNow[3] = 4;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0);
            checkOutput("thr_val", adr(0, 1), modelRead(adr(0, 1)));
            checkIrq("thr_irq", modelIrq());
        end
        checkIrq("thr_irq_high", 4'b0001);
        evNow[3] = 0;
        applyStimulus(0, 0, 0);
        applyStimulus(1, adr(0, 1), 32'd0);
        checkIrq("irq_hold", 4'b0001);
        applyStimulus(0, 0, 0);
        checkIrq("irq_drop", 4'b0000);

        // Snapshot of two counters sharing event 0, then freeze+snapshot
        applyStimulus(1, adr(0, 0), 32'h0000_0001);
        applyStimulus(1, adr(1, 0), 32'h0000_0001);
        evNow[0] = 1;
        repeat (5) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 32'h2);
`ifdef SNITCH_PERF_CNT_SNAPSHOT_EN
        checkOutput("snap0", adr(0, 5), 32'd4);
        checkOutput("snap1", adr(1, 5), 32'd4);
`else
        checkOutput("snap0_live", adr(0, 5), 32'd5);
        checkOutput("snap1_live", adr(1, 5), 32'd5);
`endif
        checkOutput("global_rd", 0, 32'h0);
        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("live_adv", adr(0, 1), 32'd8);
        checkOutput("snap_after", adr(1, 5), modelRead(adr(1, 5)));
        checkOutput("snap_hi", adr(1, 6), 32'd0);
        applyStimulus(1, 0, 32'h3);
        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("frozen0", adr(0, 1), 32'd8);
        checkOutput("frozen_snap", adr(0, 5), 32'd8);
        checkOutput("global_frz", 0, 32'h1);
        applyStimulus(1, adr(1, 1), 32'd500);
        checkOutput("frozen_wr", adr(1, 1), 32'd500);
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("unfreeze0", adr(0, 1), modelRead(adr(0, 1)));
        checkOutput("unfreeze1", adr(1, 1), modelRead(adr(1, 1)));

        // Randomized register traffic against the model
        for (int k = 0; k < 300; k++) begin
            for (int e = 0; e < 32; e++) evNow[e] = $urandom_range(0, 255);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                applyStimulus(0, 0, 0);
            end else begin
                r = $urandom_range(0, 11);
                if (r == 0)      a = 0;
                else if (r == 1) a = 1;
                else if (r == 2) a = ($urandom_range(0, 1) == 1) ? 10'h3FF : 10'h008;
                else             a = adr($urandom_range(0, 4), $urandom_range(0, 7));
                d = $urandom;
                if (a == 0) d = {30'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0)};
                else if (a >= 16 && (a - 16) % 8 == 0)
                    d = {d[31:16], 8'($urandom_range(0, 40)), d[7:0]};
                else if (a >= 16 && (a - 16) % 8 == 2 && $urandom_range(0, 1) == 1)
                    d = 32'h0000_FFFF;
                applyStimulus(1, a, d);
            end
            ra = $urandom_range(0, 56);
            if (ra == 56) ra = 10'h3FF;
            checkOutput("rand_rd", ra, modelRead(ra));
            checkIrq("rand_irq", modelIrq());
        end

        // Asynchronous reset in the middle of counting
        for (int e = 0; e < 32; e++) evNow[e] = 0;
        applyStimulus(1, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, adr(i, 0), 32'h0000_0003);
            applyStimulus(1, adr(i, 2), 32'h0);
            applyStimulus(1, adr(i, 1), 32'd1000);
            applyStimulus(1, adr(i, 4), 32'h0);
            applyStimulus(1, adr(i, 3), 32'd500);
        end
        applyStimulus(0, 0, 0);
        checkOutput("pre_rst_val", adr(2, 1), 32'd1000);
        checkIrq("pre_rst_irq", 4'b1111);
        evNow[0] = 2;
        applyStimulus(0, 0, 0);
        #20;
        rst_n = 1'b0;
        modelReset();
        checkIrq("rst_async_irq", 4'b0000);
        for (int k = 0; k < 56; k++) checkOutput("rst_async_reg", k, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(0, 0, 0);
        for (int i = 0; i < 4; i++) checkOutput("post_rst_val", adr(i, 1), 32'd0);
        checkIrq("post_rst_irq", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snitch_cluster_perf_cnt.md
SNITCH_CLUSTER_PERF_CNT -- requirements
Module: snitch_cluster_perf_cnt

Interface
REQ-001 Parameter NumCounters, default 4: number of counters, legal 1..16.
REQ-002 Parameter CounterWidth, default 48: counter width in bits, legal 33..64.
REQ-003 Parameter NumEvents, default 32: number of event inputs, legal 1..256.
REQ-004 Parameter EventWidth, default 8: per-event increment width in bits, legal 1..16.
REQ-005 Port clk_i, input, 1: the single clock; all state on its rising edge.
REQ-006 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 Port events_i, input, NumEvents x EventWidth: per-cycle unsigned increment per event.
REQ-008 Port wr_en_i, input, 1: register write strobe.
REQ-009 Port addr_i, input, 10: word address shared by read and write.
REQ-010 Port wdata_i, input, 32: write data.
REQ-011 Port rdata_o, output, 32: combinational read data at addr_i.
REQ-012 Port irq_o, output, NumCounters: registered threshold interrupt, one bit per counter.

Function
REQ-013 events_i SHALL be registered once, so an event at cycle t affects counters at edge t+1 and is visible in reads from t+2.
REQ-014 Register map:
- 0x000 GLOBAL: bit0 freeze (RW); bit1 snapshot (write-1 trigger, reads 0).
- 0x001 OVF: bit i is the sticky overflow of counter i; write-1-to-clear.
- Per counter, base 0x010+8*i:
  - +0 CTRL: bit0 en, bit1 irq_en, bits[15:8] sel.
  - +1 VAL_LO; +2 VAL_HI (bits CounterWidth-1:32, zero-extended).
  - +3 THR_LO; +4 THR_HI.
  - +5 SNAP_LO; +6 SNAP_HI.
REQ-015 Unmapped addresses SHALL read 0; writes to them SHALL be ignored.
REQ-016 Each cycle with en=1, freeze=0 and sel<NumEvents, counter i SHALL add the registered events[sel], zero-extended; otherwise it SHALL hold.
REQ-017 If sel>=NumEvents, counter i SHALL never increment.
REQ-018 On carry-out the counter SHALL wrap modulo 2^CounterWidth and set OVF bit i in the same edge.
REQ-019 OVF bits are sticky: a W1C write in the same cycle as a new overflow SHALL leave the bit set.
REQ-020 A write to VAL_LO or VAL_HI SHALL replace only the addressed bits, and SHALL take priority over any same-cycle increment, which is discarded.
REQ-021 A write to VAL_LO or VAL_HI SHALL NOT set OVF.
REQ-022 irq_o[i] SHALL be a level registered from (irq_en AND value>=threshold), using the counter's current registered value, so it lags the value by one cycle.
REQ-023 The threshold comparison SHALL be unsigned and full CounterWidth.
REQ-024 freeze=1 SHALL stop all counters within the same edge it is written; register writes SHALL still apply while frozen.
REQ-025 Writing GLOBAL bit1=1 SHALL copy all counters into the SNAP registers at that edge.
REQ-026 The snapshot SHALL capture pre-increment values, i.e. the values before that edge's increment.
REQ-027 When GLOBAL is written with freeze=1 and snapshot=1 together, the freeze and the snapshot SHALL take effect at the same edge.
REQ-028 All counters SHALL be independent; any two may select the same event.

Reset
REQ-029 While rst_ni=0, all of the following SHALL be 0: counters, thresholds, CTRL, GLOBAL, OVF, SNAP, the event pipeline register and irq_o.
REQ-030 Reset assertion mid-count SHALL clear state immediately and asynchronously.
REQ-031 Counting SHALL resume only after software sets en again.

Configuration
REQ-032 Macro SNITCH_PERF_CNT_SNAPSHOT_EN compiles in the SNAP registers and the snapshot trigger.
REQ-033 When SNITCH_PERF_CNT_SNAPSHOT_EN is undefined, no snapshot storage SHALL exist.
REQ-034 When SNITCH_PERF_CNT_SNAPSHOT_EN is undefined, SNAP_LO/SNAP_HI SHALL read the live VAL_LO/VAL_HI.
REQ-035 When SNITCH_PERF_CNT_SNAPSHOT_EN is undefined, GLOBAL bit1 SHALL be ignored.

Verification
REQ-036 Basic count: counter 0 with sel=3, en=1; drive events[3]=5 for 10 cycles, then 0 -> VAL_LO=50 and VAL_HI=0 two cycles after the last event.
REQ-037 Overflow wrap: load VAL_HI=0xFFFF and VAL_LO=0xFFFFFFFE (CounterWidth=48); increment by 3 -> value=1 and OVF=0x1; write OVF=0x1 in the same cycle as a second wrap -> OVF stays 0x1.
REQ-038 Write priority: write VAL_LO=100 in the same cycle as an increment of 7 -> VAL_LO=100 on the next cycle.
REQ-039 Threshold irq: THR_LO=20, irq_en=1, increment 4 per cycle -> irq_o[0] rises exactly one cycle after VAL_LO reads 20; write VAL_LO=0 -> irq_o[0] drops one cycle later.
REQ-040 Snapshot, macro defined: counters 0 and 1 both sel=0, incremented 1 per cycle; trigger snapshot -> SNAP values are equal, and live values keep advancing.
REQ-041 Snapshot, macro undefined: SNAP reads track the live values.
REQ-042 Reset mid-count: counters at 1000, assert rst_ni=0 for one cycle -> all registers read 0 and irq_o=0; en=0 after reset, so no counting occurs.
